// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle 6502-style ops plus multi-cycle shift-add MUL and
// restoring DIV, with start/busy/done handshaking and an updated status byte.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] accumulator,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [7:0]       status,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       status_out
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;
  state_t state, state_nx;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [7:0]       st_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mul_sum, div_trial, add_sum;
  logic [WIDTH-1:0] div_diff, add_b;
  logic             div_ge, add_c, upd_nz;
  logic [WIDTH-1:0] r, rh;
  logic [7:0]       s;

  assign busy = (state == ITER);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (op == 4'd12 || op == 4'd13) ? ITER : FINISH;
      ITER:    if (cnt == CW'(1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // hi_q/lo_q hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_trial = {hi_q, lo_q[MSB]};
    div_ge    = div_trial >= {1'b0, b_q};
    div_diff  = div_trial[WIDTH-1:0] - b_q;
  end

  always_comb begin
    add_b   = (op_q == 4'd1 || op_q == 4'd11) ? ~b_q : b_q;
    add_c   = (op_q == 4'd11) ? 1'b1 : st_q[0];
    add_sum = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
    r       = '0;
    rh      = '0;
    s       = st_q;
    upd_nz  = 1'b1;
    case (op_q)
      4'd0: begin
        r    = add_sum[WIDTH-1:0];
        s[0] = add_sum[WIDTH];
        s[6] = (a_q[MSB] == b_q[MSB]) && (r[MSB] != a_q[MSB]);
      end
      4'd1: begin
        r    = add_sum[WIDTH-1:0];
        s[0] = add_sum[WIDTH];
        s[6] = (a_q[MSB] != b_q[MSB]) && (r[MSB] != a_q[MSB]);
      end
      4'd2: r = a_q & b_q;
      4'd3: r = a_q | b_q;
      4'd4: r = a_q ^ b_q;
      4'd5: begin r = a_q << 1; s[0] = a_q[MSB]; end
      4'd6: begin r = a_q >> 1; s[0] = a_q[0]; end
      4'd7: begin r = {a_q[MSB-1:0], st_q[0]}; s[0] = a_q[MSB]; end
      4'd8: begin r = {st_q[0], a_q[MSB:1]}; s[0] = a_q[0]; end
      4'd9:  r = a_q + ONE;
      4'd10: r = a_q - ONE;
      4'd11: begin
        r      = a_q;
        upd_nz = 1'b0;
        s[0]   = add_sum[WIDTH];
        s[1]   = (a_q == b_q);
        s[7]   = add_sum[MSB];
      end
      4'd12: begin
        r      = lo_q;
        rh     = hi_q;
        upd_nz = 1'b0;
        s[0]   = |hi_q;
        s[1]   = ({hi_q, lo_q} == '0);
        s[6]   = 1'b0;
        s[7]   = hi_q[MSB];
      end
      4'd13: begin
        upd_nz = 1'b0;
        s[0]   = 1'b0;
        if (b_q == '0) begin
          r    = '1;
          rh   = a_q;
          s[1] = 1'b0;
          s[6] = 1'b1;
          s[7] = 1'b1;
        end else begin
          r    = lo_q;
          rh   = hi_q;
          s[1] = (lo_q == '0);
          s[6] = 1'b0;
        end
      end
      default: upd_nz = 1'b0;
    endcase
    if (upd_nz) begin
      s[7] = r[MSB];
      s[1] = (r == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      status_out <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      st_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          a_q  <= accumulator;
          b_q  <= operand_2;
          st_q <= status;
          hi_q <= '0;
          lo_q <= (op == 4'd12) ? operand_2 : accumulator;
          cnt  <= CW'(WIDTH);
        end
        ITER: begin
          cnt <= cnt - CW'(1);
          if (op_q == 4'd12) begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[MSB:1]};
          end else begin
            hi_q <= div_ge ? div_diff : div_trial[WIDTH-1:0];
            lo_q <= {lo_q[MSB-1:0], div_ge};
          end
        end
        FINISH: begin
          result     <= r;
          result_hi  <= rh;
          status_out <= s;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
